// File: rtl/aes_pkg.sv
// Shared definitions for the AES transmit path: widths, block/word types, byte-swap helper, TX FSM states.
package aes_pkg;
    localparam int BLK_S  = 128;
    localparam int WORD_S = 32;
    localparam int BYTE_S = 8;

    typedef logic [0:BLK_S-1]  blk_t;
    typedef logic [WORD_S-1:0] word_t;

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    function automatic word_t swap_bytes32(input word_t w);
        word_t r;
        r = '0;
        for (int i = 0; i < WORD_S / BYTE_S; i++) begin
            r[i*BYTE_S +: BYTE_S] = w[(WORD_S/BYTE_S-1-i)*BYTE_S +: BYTE_S];
        end
        return r;
    endfunction
endpackage

// File: rtl/aes_blk_fifo.sv
// Synchronous block FIFO: DEPTH entries of DATA_W bits, head visible on rdata, occupancy kept in a count.
module aes_blk_fifo #(
    parameter int DATA_W = 129,
    parameter int DEPTH  = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: the storage array is not reset; pointers and count alone decide which entries are meaningful.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/aes_blk_axis_tx.sv
// Serialises buffered 128-bit cipher blocks into 32-bit AXI4-Stream beats, tlast on the request's final beat.
// Build option: define AES_TX_BYTE_SWAP_EN to byte-reverse every beat before it reaches tdata.
module aes_blk_axis_tx
    import aes_pkg::*;
#(
    parameter int BLK_S      = 128,
    parameter int WORD_S     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:BLK_S-1]  in_blk,
    input  logic              in_last,
    output logic [WORD_S-1:0] m00_axis_tdata,
    output logic              m00_axis_tvalid,
    input  logic              m00_axis_tready,
    output logic              m00_axis_tlast,
    output logic              busy
);
    localparam int WORDS = BLK_S / WORD_S;
    localparam int WC_W  = $clog2(WORDS);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS - 1);

    tx_state_t                   state, state_nxt;
    logic [WC_W-1:0]             word_cnt;
    logic [0:BLK_S-1]            sh_reg;
    logic                        last_q;
    logic                        load;
    logic                        advance;

    logic [BLK_S:0]              fifo_rdata;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [0:BLK_S-1]            head_blk;
    logic                        head_last;
    logic [WORD_S-1:0]           cur_word;

    // No bypass: a full FIFO refuses input even when the FSM pops in the same cycle.
    assign in_ready = !fifo_full && !reset;

    aes_blk_fifo #(
        .DATA_W (BLK_S + 1),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (in_valid && in_ready),
        .wdata ({in_blk, in_last}),
        .pop   (load),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_blk  = fifo_rdata[BLK_S:1];
    assign head_last = fifo_rdata[0];

    // NOTE: every always_comb output gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        unique case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    load      = 1'b1;
                    state_nxt = TX_SEND;
                end
            end
            TX_SEND: begin
                if (m00_axis_tready) begin
                    if (word_cnt != LAST_WORD) advance   = 1'b1;
                    else if (!fifo_empty)      load      = 1'b1;
                    else                       state_nxt = TX_IDLE;
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= TX_IDLE;
            word_cnt <= '0;
            sh_reg   <= '0;
            last_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                sh_reg   <= head_blk;
                last_q   <= head_last;
                word_cnt <= '0;
            end else if (advance) begin
                sh_reg   <= sh_reg << WORD_S;
                word_cnt <= word_cnt + WC_W'(1);
            end
        end
    end

    // The current word always sits in the MSB slot of the shift register.
    assign cur_word = sh_reg[0:WORD_S-1];

`ifdef AES_TX_BYTE_SWAP_EN
    assign m00_axis_tdata = swap_bytes32(cur_word);
`else
    assign m00_axis_tdata = cur_word;
`endif

    assign m00_axis_tvalid = (state == TX_SEND);
    assign m00_axis_tlast  = m00_axis_tvalid && (word_cnt == LAST_WORD) && last_q;
    assign busy            = (fifo_count != '0) || (state == TX_SEND);
endmodule

// File: tb/tb_aes_blk_axis_tx.sv
// Self-checking bench for aes_blk_axis_tx: random blocks scored against a per-block beat model.
module tb_aes_blk_axis_tx;
    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [127:0]  in_blk = '0;
    logic          in_last = 1'b0;
    logic [31:0]   m00_axis_tdata;
    logic          m00_axis_tvalid;
    logic          m00_axis_tready = 1'b0;
    logic          m00_axis_tlast;
    logic          busy;

    aes_blk_axis_tx dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_blk          (in_blk),
        .in_last         (in_last),
        .m00_axis_tdata  (m00_axis_tdata),
        .m00_axis_tvalid (m00_axis_tvalid),
        .m00_axis_tready (m00_axis_tready),
        .m00_axis_tlast  (m00_axis_tlast),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t         exp_q[$];
    logic [31:0]   obs_data[$];
    logic          obs_last[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int beats = 0;
    int first_beat_cyc = -1;
    int last_beat_cyc = -1;
    bit pushed;
    bit saw_not_ready;
    bit saw_tlast;
    bit stall_pending = 1'b0;
    logic [31:0] stall_data;
    logic        stall_last;

    logic          d_reset = 1'b1;
    logic          d_valid = 1'b0;
    logic [127:0]  d_blk = '0;
    logic          d_last = 1'b0;
    logic          d_ready = 1'b1;
    int            ready_mode = 0;

    // Expected beat k of a block: bits [127-32k -: 32], byte-reversed in the swap build.
    function automatic logic [31:0] model_word(input logic [127:0] b, input int k);
        logic [31:0] w;
        w = b[127-32*k -: 32];
`ifdef AES_TX_BYTE_SWAP_EN
        w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
        return w;
    endfunction

    function automatic logic [127:0] rand_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic clear_stats();
        beats = 0;
        first_beat_cyc = -1;
        last_beat_cyc = -1;
        saw_not_ready = 1'b0;
        saw_tlast = 1'b0;
        obs_data.delete();
        obs_last.delete();
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, score what the next rising edge will commit.
    task automatic step();
        beat_t e;
        @(negedge clock);
        if (ready_mode == 1) d_ready = ((cyc % 8) >= 2);
        else if (ready_mode == 2) d_ready = ($urandom_range(0, 3) != 0);
        reset = d_reset;
        in_valid = d_valid;
        in_blk = d_blk;
        in_last = d_last;
        m00_axis_tready = d_ready;
        #1;
        pushed = 1'b0;
        if (reset) begin
            exp_q.delete();
            stall_pending = 1'b0;
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL in_ready_during_reset: got %b want 0", in_ready);
            end
        end else begin
            if (in_ready !== 1'b1) saw_not_ready = 1'b1;
            if (m00_axis_tvalid === 1'b1 && m00_axis_tlast === 1'b1) saw_tlast = 1'b1;
            if (in_valid && in_ready === 1'b1) begin
                pushed = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    e.data = model_word(in_blk, k);
                    e.last = in_last && (k == 3);
                    exp_q.push_back(e);
                end
            end
            if (stall_pending) begin
                vectors++;
                if (m00_axis_tvalid !== 1'b1 || m00_axis_tdata !== stall_data || m00_axis_tlast !== stall_last) begin
                    miscompares++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast, stall_data, stall_last);
                end
            end
            if (m00_axis_tvalid === 1'b1 && m00_axis_tready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_beat: got d=%h l=%b want no beat", m00_axis_tdata, m00_axis_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if (m00_axis_tdata !== e.data || m00_axis_tlast !== e.last) begin
                        miscompares++;
                        $display("FAIL beat: got d=%h l=%b want d=%h l=%b",
                                 m00_axis_tdata, m00_axis_tlast, e.data, e.last);
                    end
                end
                obs_data.push_back(m00_axis_tdata);
                obs_last.push_back(m00_axis_tlast);
                beats++;
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
            end
            stall_pending = (m00_axis_tvalid === 1'b1) && !m00_axis_tready;
            stall_data = m00_axis_tdata;
            stall_last = m00_axis_tlast;
        end
        cyc++;
    endtask

    task automatic push_block(input logic [127:0] b, input logic l);
        int n;
        n = 0;
        d_valid = 1'b1;
        d_blk = b;
        d_last = l;
        do begin
            step();
            n++;
        end while (!pushed && n < 200);
        d_valid = 1'b0;
        if (!pushed) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: got no accept in %0d cycles want accept", n);
        end
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        d_valid = 1'b0;
        do begin
            step();
            n++;
        end while ((exp_q.size() != 0 || busy !== 1'b0) && n < max_cyc);
        vectors++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d beats outstanding busy=%b want 0 and 0", exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        d_reset = 1'b1;
        d_valid = 1'b0;
        d_ready = 1'b1;
        ready_mode = 0;
        repeat (3) step();
        d_reset = 1'b0;
        step();
        vectors += 5;
        if (m00_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b want 0", m00_axis_tvalid); end
        if (m00_axis_tlast !== 1'b0)  begin miscompares++; $display("FAIL reset_tlast: got %b want 0", m00_axis_tlast); end
        if (m00_axis_tdata !== 32'h0) begin miscompares++; $display("FAIL reset_tdata: got %h want 0", m00_axis_tdata); end
        if (busy !== 1'b0)            begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (in_ready !== 1'b1)        begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single_block();
        logic [31:0] want [4];
        logic [127:0] vec;
`ifdef AES_TX_BYTE_SWAP_EN
        want = '{32'hd8e0c469, 32'h30047b6a, 32'h80b7cdd8, 32'h5ac5b470};
`else
        want = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
`endif
        vec = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        clear_stats();
        ready_mode = 0;
        d_ready = 1'b1;
        d_valid = 1'b1;
        d_blk = vec;
        d_last = 1'b1;
        step();
        d_valid = 1'b0;
        vectors++;
        if (pushed !== 1'b1) begin miscompares++; $display("FAIL single_accept: got %b want 1", pushed); end
        step();
        vectors++;
        if (m00_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL latency_n1: got tvalid=%b want 0", m00_axis_tvalid); end
        step();
        vectors++;
        if (m00_axis_tvalid !== 1'b1 || m00_axis_tdata !== want[0]) begin
            miscompares++;
            $display("FAIL latency_n2: got v=%b d=%h want v=1 d=%h", m00_axis_tvalid, m00_axis_tdata, want[0]);
        end
        repeat (3) step();
        step();
        vectors += 2;
        if (m00_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle: got v=%b busy=%b want 0 0", m00_axis_tvalid, busy);
        end
        if (beats != 4) begin
            miscompares++;
            $display("FAIL single_beats: got %0d want 4", beats);
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (obs_data[k] !== want[k] || obs_last[k] !== (k == 3)) begin
                    miscompares++;
                    $display("FAIL single_word%0d: got d=%h l=%b want d=%h l=%b", k, obs_data[k], obs_last[k], want[k], k == 3);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        ready_mode = 0;
        d_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_block(rand_blk(), i == 2);
        drain(100);
        vectors += 3;
        if (beats != 12) begin miscompares++; $display("FAIL b2b_beats: got %0d want 12", beats); end
        if (last_beat_cyc - first_beat_cyc != 11) begin
            miscompares++;
            $display("FAIL b2b_bubble: got span %0d want 11", last_beat_cyc - first_beat_cyc);
        end
        if (saw_not_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_full: got in_ready never low want low"); end
    endtask

    task automatic test_stall();
        clear_stats();
        ready_mode = 1;
        for (int i = 0; i < 5; i++) push_block(rand_blk(), 1'($urandom_range(0, 1)));
        drain(200);
        ready_mode = 0;
        vectors++;
        if (beats != 20) begin miscompares++; $display("FAIL stall_beats: got %0d want 20", beats); end
    endtask

    task automatic test_no_last();
        int n;
        logic busy_at_final;
        clear_stats();
        ready_mode = 0;
        d_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_block(rand_blk(), 1'b0);
        n = 0;
        busy_at_final = 1'b0;
        while (beats < 12 && n < 100) begin
            step();
            busy_at_final = busy;
            n++;
        end
        step();
        vectors += 3;
        if (busy_at_final !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_fall: got final=%b next=%b want 1 0", busy_at_final, busy);
        end
        if (saw_tlast !== 1'b0) begin miscompares++; $display("FAIL no_last_tlast: got tlast seen want never"); end
        if (beats != 12) begin miscompares++; $display("FAIL no_last_beats: got %0d want 12", beats); end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_stats();
        ready_mode = 0;
        d_ready = 1'b1;
        push_block(rand_blk(), 1'b1);
        n = 0;
        while (beats < 2 && n < 50) begin
            step();
            n++;
        end
        d_reset = 1'b1;
        step();
        d_reset = 1'b0;
        step();
        vectors += 3;
        if (m00_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_tvalid: got %b want 0", m00_axis_tvalid); end
        if (busy !== 1'b0)            begin miscompares++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        if (in_ready !== 1'b1)        begin miscompares++; $display("FAIL mid_reset_in_ready: got %b want 1", in_ready); end
        clear_stats();
        push_block(rand_blk(), 1'b1);
        drain(100);
        vectors++;
        if (beats != 4) begin miscompares++; $display("FAIL mid_reset_next: got %0d beats want 4", beats); end
    endtask

    task automatic test_push_pop();
        int n;
        bit c_done;
        clear_stats();
        ready_mode = 0;
        d_ready = 1'b1;
        push_block(rand_blk(), 1'b0);
        push_block(rand_blk(), 1'b0);
        n = 0;
        c_done = 1'b0;
        while (!c_done && n < 30) begin
            d_valid = (beats == 3);
            d_blk = rand_blk();
            d_last = 1'b1;
            step();
            if (d_valid) begin
                c_done = 1'b1;
                vectors++;
                if (pushed !== 1'b1) begin miscompares++; $display("FAIL push_pop_accept: got %b want 1", pushed); end
            end
            n++;
        end
        d_valid = 1'b0;
        step();
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL push_pop_count: got in_ready=%b want 1", in_ready); end
        drain(100);
        vectors++;
        if (beats != 12) begin miscompares++; $display("FAIL push_pop_beats: got %0d want 12", beats); end
    endtask

    task automatic test_random();
        clear_stats();
        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            d_valid = ($urandom_range(0, 2) == 0);
            d_blk = rand_blk();
            d_last = 1'($urandom_range(0, 1));
            step();
        end
        drain(500);
        ready_mode = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_stall();
        test_no_last();
        test_reset_mid();
        test_push_pop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
